// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and fixed-latency sequencer for the word-addressed Y86-64 data memory.
// Define DMEM_ARB_STATS_EN to enable the saturating grant/conflict counters; otherwise they read 0.
module dmem_arbiter #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [63:0]       wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [63:0]       wdata1,
    output logic              done0,
    output logic              done1,
    output logic [63:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        CNT_INIT   = 4'(LAT - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_nextState;

    logic                r_lastGnt;
    logic                r_port;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [63:0]         r_wdata;
    logic [3:0]          r_cnt;
    logic [63:0]         r_rdata;
    logic                r_err;

    logic [63:0]         r_mem [0:DEPTH-1];

    logic                w_anyReq;
    logic                w_grant1;
    logic                w_grantEvent;
    logic                w_access;
    logic                w_inRange;
    logic [IDX_W-1:0]    w_idx;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        w_anyReq     = req0 | req1;
        w_grant1     = req1 & (~req0 | ~r_lastGnt);
        w_grantEvent = (r_state == S_IDLE) & w_anyReq;
        w_access     = (r_state == S_BUSY) & (r_cnt == 4'd0);
        w_inRange    = ({1'b0, r_addr} < DEPTH_EXT);
        w_idx        = r_addr[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_anyReq) begin
                    w_nextState = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_comb begin
        done0 = (r_state == S_DONE) & ~r_port;
        done1 = (r_state == S_DONE) & r_port;
        busy  = (r_state != S_IDLE);
        rdata = r_rdata;
        err   = r_err;
    end

    // Request fields are captured at grant so the requester's inputs are ignored during BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lastGnt <= 1'b1;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= 4'd0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_port    <= w_grant1;
                        r_lastGnt <= w_grant1;
                        r_we      <= w_grant1 ? we1 : we0;
                        r_addr    <= w_grant1 ? addr1 : addr0;
                        r_wdata   <= w_grant1 ? wdata1 : wdata0;
                        r_cnt     <= CNT_INIT;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!w_inRange) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else if (r_we) begin
                        r_rdata <= r_wdata;
                    end else begin
                        r_rdata <= r_mem[w_idx];
                    end
                end
                S_DONE: begin
                    r_err <= 1'b0;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; a reset during BUSY suppresses the pending write.
    always_ff @(posedge clk) begin
        if (rst_n && w_access && r_we && w_inRange) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_gntCnt0;
    logic [15:0] r_gntCnt1;
    logic [15:0] r_conflictCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gntCnt0     <= '0;
            r_gntCnt1     <= '0;
            r_conflictCnt <= '0;
        end else begin
            if (w_grantEvent && !w_grant1 && (r_gntCnt0 != 16'hFFFF)) begin
                r_gntCnt0 <= r_gntCnt0 + 16'd1;
            end
            if (w_grantEvent && w_grant1 && (r_gntCnt1 != 16'hFFFF)) begin
                r_gntCnt1 <= r_gntCnt1 + 16'd1;
            end
            if ((r_state == S_IDLE) && req0 && req1 && (r_conflictCnt != 16'hFFFF)) begin
                r_conflictCnt <= r_conflictCnt + 16'd1;
            end
        end
    end

    always_comb begin
        gnt_cnt0     = r_gntCnt0;
        gnt_cnt1     = r_gntCnt1;
        conflict_cnt = r_conflictCnt;
    end
`else
    logic w_unusedGrant;

    always_comb begin
        w_unusedGrant = w_grantEvent;
        gnt_cnt0      = 16'h0000;
        gnt_cnt1      = 16'h0000;
        conflict_cnt  = 16'h0000;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: randomized and directed two-port traffic checked against
// a plain associative-array memory model applied in completion order.
module tb_dmem_arbiter;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 10;
    localparam int LAT    = 2;
    localparam int WAIT_BOUND = 2 * (LAT + 2);

    logic              clk;
    logic              rst_n;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [63:0]       wdata0, wdata1;
    logic              done0, done1, err, busy;
    logic [63:0]       rdata;
    logic [15:0]       gnt_cnt0, gnt_cnt1, conflict_cnt;

    typedef struct {
        bit          we;
        int          addr;
        logic [63:0] wdata;
        int          gap;
    } plan_t;

    typedef struct {
        bit          we;
        int          addr;
        logic [63:0] wdata;
        int          issued;
    } exp_t;

    plan_t       plan0[$];
    plan_t       plan1[$];
    exp_t        sb0[$];
    exp_t        sb1[$];
    int          completedOrder[$];
    logic [63:0] refMem [int];

    int nChecks = 0;
    int nFails  = 0;
    int cycle   = 0;
    int compl0  = 0;
    int compl1  = 0;

    dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .done0        (done0),
        .done1        (done1),
        .rdata        (rdata),
        .err          (err),
        .busy         (busy),
        .gnt_cnt0     (gnt_cnt0),
        .gnt_cnt1     (gnt_cnt1),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    task automatic addPlan(input int p, input bit we, input int addr, input logic [63:0] d, input int gap);
        plan_t a;
        a.we = we; a.addr = addr; a.wdata = d; a.gap = gap;
        if (p == 0) plan0.push_back(a);
        else        plan1.push_back(a);
    endtask

    function automatic bit donePort(input int p);
        return (p == 0) ? done0 : done1;
    endfunction

    // Entered just after a rising edge; returns just after the edge that ends the done cycle.
    task automatic applyStimulus(input int p, input int n, input bit checkSolo);
        plan_t a;
        exp_t  e;
        int    waited;
        for (int k = 0; k < n; k++) begin
            if (p == 0) a = plan0.pop_front();
            else        a = plan1.pop_front();
            repeat (a.gap) begin
                @(posedge clk);
                #1;
            end
            e.we = a.we; e.addr = a.addr; e.wdata = a.wdata; e.issued = cycle;
            if (p == 0) begin
                req0 = 1'b1; we0 = a.we; addr0 = a.addr[ADDR_W-1:0]; wdata0 = a.wdata;
                sb0.push_back(e);
            end else begin
                req1 = 1'b1; we1 = a.we; addr1 = a.addr[ADDR_W-1:0]; wdata1 = a.wdata;
                sb1.push_back(e);
            end
            waited = 0;
            forever begin
                @(negedge clk);
                waited++;
                if (donePort(p) || waited >= 100) break;
            end
            if (!donePort(p)) checkOutput($sformatf("timeout_port%0d", p), 64'd0, 64'd1);
            if (checkSolo) checkOutput($sformatf("solo_latency_port%0d", p), 64'(waited), 64'(LAT + 2));
            if (p == 0) req0 = 1'b0;
            else        req1 = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic handleDone(input int p);
        exp_t        e;
        logic [63:0] expData;
        bit          expErr;
        bit          known;
        if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
            checkOutput($sformatf("spurious_done%0d", p), 64'd1, 64'd0);
            return;
        end
        e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
        completedOrder.push_back(p);
        if (p == 0) compl0++;
        else        compl1++;
        known = 1'b1;
        expErr = 1'b0;
        expData = 64'd0;
        if (e.addr >= DEPTH) begin
            expErr = 1'b1;
        end else if (e.we) begin
            refMem[e.addr] = e.wdata;
            expData = e.wdata;
        end else if (refMem.exists(e.addr)) begin
            expData = refMem[e.addr];
        end else begin
            known = 1'b0;
        end
        checkOutput($sformatf("err_port%0d_addr%0d", p, e.addr), 64'(err), 64'(expErr));
        if (known) checkOutput($sformatf("rdata_port%0d_addr%0d", p, e.addr), rdata, expData);
        checkOutput($sformatf("wait_bound_port%0d", p), 64'((cycle - e.issued) <= WAIT_BOUND), 64'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done0 || done1) begin
                checkOutput("done_overlap", 64'(done0 & done1), 64'd0);
                if (done0) handleDone(0);
                if (done1) handleDone(1);
            end
        end
    end

    task automatic checkOrder(input string name, input int expOrder[$]);
        checkOutput({name, "_len"}, 64'(completedOrder.size()), 64'(expOrder.size()));
        for (int i = 0; i < expOrder.size() && i < completedOrder.size(); i++)
            checkOutput($sformatf("%s_%0d", name, i), 64'(completedOrder[i]), 64'(expOrder[i]));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},  64'(busy),  64'd0);
        checkOutput({tag, "_done0"}, 64'(done0), 64'd0);
        checkOutput({tag, "_done1"}, 64'(done1), 64'd0);
        checkOutput({tag, "_rdata"}, rdata,      64'd0);
        checkOutput({tag, "_err"},   64'(err),   64'd0);
        checkOutput({tag, "_gnt0"},  64'(gnt_cnt0),     64'd0);
        checkOutput({tag, "_gnt1"},  64'(gnt_cnt1),     64'd0);
        checkOutput({tag, "_confl"}, 64'(conflict_cnt), 64'd0);
    endtask

    initial begin
        int expOrder[$];
        int addrR;
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compl0 = 0; compl1 = 0;

        $display("[TB] ties after reset with counters");
        completedOrder.delete();
        addPlan(0, 1'b1, 1,   64'h1111_0000_0000_0001, 0);
        addPlan(0, 1'b1, 3,   64'h3333_0000_0000_0003, 0);
        addPlan(1, 1'b1, 2,   64'h2222_0000_0000_0002, 0);
        addPlan(1, 1'b1, 4,   64'h4444_0000_0000_0004, 0);
        addPlan(1, 1'b1, 600, 64'h6666_0000_0000_0600, 0);
        fork
            applyStimulus(0, 2, 1'b0);
            applyStimulus(1, 3, 1'b0);
        join
        expOrder = '{0, 1, 0, 1, 1};
        checkOrder("tie_order", expOrder);
`ifdef DMEM_ARB_STATS_EN
        checkOutput("gnt_cnt0", 64'(gnt_cnt0), 64'd2);
        checkOutput("gnt_cnt1", 64'(gnt_cnt1), 64'd3);
        checkOutput("conflict_cnt_min3", 64'(conflict_cnt >= 16'd3), 64'd1);
`else
        checkOutput("gnt_cnt0", 64'(gnt_cnt0), 64'd0);
        checkOutput("gnt_cnt1", 64'(gnt_cnt1), 64'd0);
        checkOutput("conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif

        $display("[TB] solo write then read through the other port");
        addPlan(1, 1'b1, 5, 64'hDEADBEEF_00000001, 0);
        applyStimulus(1, 1, 1'b1);
        addPlan(0, 1'b0, 5, 64'd0, 1);
        applyStimulus(0, 1, 1'b1);

        $display("[TB] continuous port 0 with a single port 1 request");
        completedOrder.delete();
        addPlan(0, 1'b0, 1, 64'd0, 0);
        addPlan(0, 1'b0, 2, 64'd0, 0);
        addPlan(0, 1'b0, 3, 64'd0, 0);
        addPlan(1, 1'b0, 4, 64'd0, 0);
        fork
            applyStimulus(0, 3, 1'b0);
            begin
                @(posedge clk);
                #1;
                applyStimulus(1, 1, 1'b0);
            end
        join
        expOrder = '{0, 1, 0, 0};
        checkOrder("no_starve_order", expOrder);

        $display("[TB] out-of-range accesses");
        addPlan(0, 1'b1, 88,  64'h0000_AAAA_0000_AAAA, 1);
        addPlan(0, 1'b1, 600, 64'h0000_BBBB_0000_BBBB, 0);
        addPlan(0, 1'b0, 600, 64'd0, 0);
        addPlan(0, 1'b0, 88,  64'd0, 0);
        applyStimulus(0, 4, 1'b0);

        $display("[TB] reset during an access");
        addPlan(0, 1'b1, 9, 64'h0, 0);
        addPlan(0, 1'b1, 7, 64'h1234, 0);
        applyStimulus(0, 2, 1'b0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd9; wdata0 = 64'h55;
        @(posedge clk);
        #1;
        checkOutput("busy_in_access", 64'(busy), 64'd1);
        rst_n = 1'b0;
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("midreset");
        rst_n = 1'b1;
        compl0 = 0; compl1 = 0;
        @(posedge clk);
        #1;
        addPlan(0, 1'b0, 9, 64'd0, 0);
        applyStimulus(0, 1, 1'b1);

        $display("[TB] randomized traffic");
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 30; k++) begin
                addrR = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 15)) : int'($urandom_range(505, 1023));
                addPlan(p, bit'($urandom_range(0, 1)), addrR, {$urandom, $urandom}, int'($urandom_range(0, 3)));
            end
        end
        fork
            applyStimulus(0, 30, 1'b0);
            applyStimulus(1, 30, 1'b0);
        join
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("sb0_drained", 64'(sb0.size()), 64'd0);
        checkOutput("sb1_drained", 64'(sb1.size()), 64'd0);
`ifdef DMEM_ARB_STATS_EN
        checkOutput("gnt_cnt0_total", 64'(gnt_cnt0), 64'(compl0));
        checkOutput("gnt_cnt1_total", 64'(gnt_cnt1), 64'(compl1));
`else
        checkOutput("gnt_cnt0_total", 64'(gnt_cnt0), 64'd0);
        checkOutput("gnt_cnt1_total", 64'(gnt_cnt1), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        nFails++;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the 64-bit, word-addressed Y86-64 data memory.
- Port 0: the pipeline memory stage. It issues rmmovq/mrmovq/call/ret/pushq/popq accesses using valE or valA as the address.
- Port 1: the loader/debug port. It preloads and inspects memory.
- Owns the storage array. Grants one requester at a time with round-robin fairness and models a fixed multi-cycle access latency through a small FSM.

Parameters:
- DEPTH, 1024, number of 64-bit words in the array.
- ADDR_W, 10, address width in words.
- LAT, 2, access latency in cycles spent in BUSY; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0  in  1  port 0 request; held high until done0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  64  port 0 write data.
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/64  port 1, same meaning as port 0.
- done0  out  1  one-cycle completion pulse for port 0.
- done1  out  1  one-cycle completion pulse for port 1.
- rdata  out  64  read data; valid while done0 or done1 is high.
- err  out  1  high with done when the address was ≥ DEPTH.
- busy  out  1  high whenever state ≠ IDLE.
- gnt_cnt0  out  16  grants issued to port 0 (optional feature).
- gnt_cnt1  out  16  grants issued to port 1 (optional feature).
- conflict_cnt  out  16  cycles in which both ports were granted-eligible (optional feature).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values: state=IDLE, done0=done1=0, rdata=0, err=0, busy=0, last_gnt=1, cnt=0, all counters 0. Array contents are not reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one reqN is high, grant N.
  - If both are high, grant the port ≠ last_gnt. Port 0 therefore wins the first tie after reset.
  - On grant, latch port id, we, addr and wdata into internal registers, set last_gnt=N, cnt=LAT-1, and go to BUSY.
- BUSY:
  - Requester inputs are ignored.
  - If cnt≠0: decrement cnt and stay in BUSY.
  - If cnt==0: perform the access using the latched values, then go to DONE.
    - Write: mem[addr]←wdata; rdata←wdata.
    - Read: rdata←mem[addr].
    - If addr ≥ DEPTH: no write, rdata←0, err←1.
  - A write is committed only at this edge.
- DONE:
  - doneN=1 for the latched port only, for exactly one cycle; rdata and err remain valid.
  - Next edge: return to IDLE and clear doneN and err. rdata holds its value.
- Latency: a request accepted at edge E0 raises done at edge E0+LAT and falls at E0+LAT+1. Re-arbitration happens in IDLE only, so back-to-back throughput is one access per LAT+2 cycles.
- Handshake:
  - A requester keeps req, we, addr and wdata stable until its done pulse.
  - It deasserts req in the done cycle. A req still high in the following IDLE cycle is a new request.
  - Dropping req while in BUSY does not cancel the access; it completes and done still pulses.
- Other requester: a request from the port not being served waits. It is granted on the next IDLE edge and is guaranteed service within one access.
- Simultaneous same-address accesses: fully serialized in grant order; the second access sees the effect of the first.
- Reset mid-operation: rst_n low in BUSY abandons the access with no array write; state goes to IDLE and all outputs take reset values. Reset in DONE also returns to IDLE immediately.
- Width rules: addresses are zero-extended for the comparison against DEPTH; no wrap-around. When DEPTH = 2^ADDR_W, err is never asserted.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, three saturating 16-bit counters are active:
  - gnt_cnt0 increments on each grant to port 0.
  - gnt_cnt1 increments on each grant to port 1.
  - conflict_cnt increments on each IDLE cycle with req0 and req1 both high.
  - Each counter holds at 16'hFFFF and clears on reset.
- When undefined, the ports remain but are tied to 0, and no counter logic is generated.

Test Plan:
- Port 1 writes 64'hDEADBEEF_00000001 to addr 5 (LAT=2); then port 0 reads addr 5 -> done1 two edges after grant; port 0 done0 with rdata=64'hDEADBEEF_00000001, err=0.
- req0 and req1 raised together (addr0=1, addr1=2) right after reset -> port 0 served first, then port 1. In the next tie, port 1 wins (last_gnt=0); done pulses never overlap.
- Port 0 holds req continuously while port 1 requests once -> port 1 is granted at the first IDLE after port 0's access; no starvation.
- DEPTH=512: port 0 writes addr 600, then reads addr 600 -> write err=1 with array unchanged; read rdata=0, err=1.
- rst_n low for one cycle during BUSY of a write of 64'h55 to addr 9 (previously 64'h0) -> outputs go to reset values; a later read of addr 9 returns 64'h0.
- With DMEM_ARB_STATS_EN, run 3 ties plus 2 solo port-1 accesses -> gnt_cnt0=2, gnt_cnt1=3, conflict_cnt ≥ 3. Without the macro, all three read 0.
